// File: rtl/ex_forward_ctrl_if.sv
// ID-side bus of the EX forwarding / load-use controller.
// Master drives the ID instruction fields, slave returns selects and stall.
interface ex_forward_ctrl_if;
  logic       id_valid;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_src1_used;
  logic       id_src2_used;
  logic [2:0] id_dest;
  logic       id_regwrite;
  logic       id_is_load;
  logic       advance;
  logic       flush;
  logic [1:0] alu_input_one_mux_sel;
  logic [1:0] alu_input_two_mux_sel;
  logic       stall_id;

  modport master (
    output id_valid, id_src1, id_src2,
    output id_src1_used, id_src2_used,
    output id_dest, id_regwrite, id_is_load,
    output advance, flush,
    input  alu_input_one_mux_sel,
    input  alu_input_two_mux_sel,
    input  stall_id
  );

  modport slave (
    input  id_valid, id_src1, id_src2,
    input  id_src1_used, id_src2_used,
    input  id_dest, id_regwrite, id_is_load,
    input  advance, flush,
    output alu_input_one_mux_sel,
    output alu_input_two_mux_sel,
    output stall_id
  );
endinterface

// File: rtl/ex_forward_ctrl.sv
// EX-stage operand forwarding and load-use stall control for LC-3b.
// FWD_MEM_LOAD_EN: forward loads from MEM (select 3), no load-use stall.
module ex_forward_ctrl (
  input  logic               clk,
  input  logic               reset,
  ex_forward_ctrl_if.slave   fwd
);

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       regwrite;
    logic       is_load;
  } stg_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       regwrite;
  } wb_t;

  stg_t       r_ex;
  stg_t       r_mem;
  wb_t        r_wb;
  logic [2:0] r_ex_src1;
  logic [2:0] r_ex_src2;
  logic       r_ex_src1_used;
  logic       r_ex_src2_used;
  logic       w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex           <= '0;
      r_mem          <= '0;
      r_wb           <= '0;
      r_ex_src1      <= '0;
      r_ex_src2      <= '0;
      r_ex_src1_used <= 1'b0;
      r_ex_src2_used <= 1'b0;
    end else if (fwd.advance) begin
      r_wb           <= '{r_mem.valid, r_mem.dest, r_mem.regwrite};
      r_mem          <= r_ex;
      r_ex.valid     <= fwd.id_valid & ~fwd.flush & ~w_stall;
      r_ex.dest      <= fwd.id_dest;
      r_ex.regwrite  <= fwd.id_regwrite;
      r_ex.is_load   <= fwd.id_is_load;
      r_ex_src1      <= fwd.id_src1;
      r_ex_src2      <= fwd.id_src2;
      r_ex_src1_used <= fwd.id_src1_used;
      r_ex_src2_used <= fwd.id_src2_used;
    end
  end

  function automatic logic [1:0] sel_f(
    input logic       ex_ok,
    input logic [2:0] src,
    input stg_t       mem,
    input wb_t        wb
  );
    logic mhit;
    logic whit;
    mhit  = mem.valid & mem.regwrite & (mem.dest == src);
    whit  = wb.valid & wb.regwrite & (wb.dest == src);
    sel_f = 2'd0;
    if (ex_ok) begin
      if (mhit && !mem.is_load)
        sel_f = 2'd1;
`ifdef FWD_MEM_LOAD_EN
      else if (mhit)
        sel_f = 2'd3;
`endif
      else if (whit)
        sel_f = 2'd2;
    end
  endfunction

  assign fwd.alu_input_one_mux_sel =
    sel_f(r_ex.valid & r_ex_src1_used, r_ex_src1, r_mem, r_wb);
  assign fwd.alu_input_two_mux_sel =
    sel_f(r_ex.valid & r_ex_src2_used, r_ex_src2, r_mem, r_wb);

`ifdef FWD_MEM_LOAD_EN
  assign w_stall = 1'b0;
`else
  typedef enum logic {IDLE, LU_STALL} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_hazard;

  assign w_hazard =
    r_ex.valid & r_ex.is_load & r_ex.regwrite & fwd.id_valid &
    ((fwd.id_src1_used & (fwd.id_src1 == r_ex.dest)) |
     (fwd.id_src2_used & (fwd.id_src2 == r_ex.dest)));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (fwd.advance) begin
      if (fwd.flush) begin
        w_state_nxt = IDLE;
      end else begin
        unique case (r_state)
          IDLE:     if (w_hazard) w_state_nxt = LU_STALL;
          LU_STALL: w_state_nxt = IDLE;
          default:  w_state_nxt = IDLE;
        endcase
      end
    end
  end

  // the bubble already separates load and user once in LU_STALL
  always_comb begin
    w_stall = 1'b0;
    if (r_state == IDLE)
      w_stall = w_hazard & ~(fwd.flush & fwd.advance);
  end
`endif

  assign fwd.stall_id = w_stall;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Bench for ex_forward_ctrl: directed vector table plus random
// stimulus checked against a pipeline-level reference model.
module tb_ex_forward_ctrl;

`ifdef FWD_MEM_LOAD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic ST = FWD ? 1'b0 : 1'b1;

  logic clk = 1'b0;
  logic reset;

  ex_forward_ctrl_if bus();

  ex_forward_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .fwd   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [2:0] d;
    logic       rw;
    logic       ld;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
  } ins_t;

  typedef struct {
    ins_t       id;
    bit         adv;
    bit         fl;
    bit         rst;
    logic [1:0] e1;
    logic [1:0] e2;
    logic       es;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ins_t pipe [3];
  bit   m_stalled;
  vec_t tbl [$];

  function automatic ins_t alu(input logic [2:0] d, input logic [2:0] s1,
                               input logic u1, input logic [2:0] s2,
                               input logic u2);
    ins_t r;
    r = '{v:1'b1, d:d, rw:1'b1, ld:1'b0, s1:s1, u1:u1, s2:s2, u2:u2};
    return r;
  endfunction

  function automatic ins_t ldr(input logic [2:0] d, input logic [2:0] b);
    ins_t r;
    r = '{v:1'b1, d:d, rw:1'b1, ld:1'b1, s1:b, u1:1'b1, s2:3'd0, u2:1'b0};
    return r;
  endfunction

  function automatic void add(input ins_t id, input bit adv, input bit fl,
                              input bit rst, input logic [1:0] e1,
                              input logic [1:0] e2, input logic es);
    vec_t v;
    v = '{id:id, adv:adv, fl:fl, rst:rst, e1:e1, e2:e2, es:es};
    tbl.push_back(v);
  endfunction

  function automatic bit writes(input ins_t p, input logic [2:0] r);
    return p.v && p.rw && p.d == r;
  endfunction

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  function automatic logic [1:0] m_sel(input logic [2:0] s, input logic u);
    if (!pipe[0].v || !u) return 2'd0;
    if (writes(pipe[1], s)) begin
      if (!pipe[1].ld) return 2'd1;
      if (FWD) return 2'd3;
    end
    if (writes(pipe[2], s)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_stall(input ins_t id, input bit adv,
                                   input bit fl);
    bit dep;
    dep = (id.u1 && id.s1 == pipe[0].d) || (id.u2 && id.s2 == pipe[0].d);
    if (FWD || m_stalled || (fl && adv)) return 1'b0;
    return id.v && pipe[0].v && pipe[0].ld && pipe[0].rw && dep;
  endfunction

  function automatic void m_clock(input ins_t id, input bit adv,
                                  input bit fl, input bit rst,
                                  input bit st);
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_stalled = 1'b0;
    end else if (adv) begin
      pipe[2]   = pipe[1];
      pipe[1]   = pipe[0];
      pipe[0]   = id;
      if (fl || st) pipe[0].v = 1'b0;
      m_stalled = st;
    end
  endfunction

  task automatic drive(input ins_t id, input bit adv, input bit fl,
                       input bit rst);
    bus.id_valid     = id.v;
    bus.id_dest      = id.d;
    bus.id_regwrite  = id.rw;
    bus.id_is_load   = id.ld;
    bus.id_src1      = id.s1;
    bus.id_src1_used = id.u1;
    bus.id_src2      = id.s2;
    bus.id_src2_used = id.u2;
    bus.advance      = adv;
    bus.flush        = fl;
    reset            = rst;
  endtask

  task automatic step(input string nm, input ins_t id, input bit adv,
                      input bit fl, input bit rst, input bit use_model,
                      input logic [1:0] e1, input logic [1:0] e2,
                      input logic es);
    logic [1:0] x1;
    logic [1:0] x2;
    logic       xs;
    xs = m_stall(id, adv, fl);
    x1 = use_model ? m_sel(pipe[0].s1, pipe[0].u1) : e1;
    x2 = use_model ? m_sel(pipe[0].s2, pipe[0].u2) : e2;
    if (!use_model) xs = es;
    drive(id, adv, fl, rst);
    @(negedge clk);
    n_tests++;
    if (bus.alu_input_one_mux_sel !== x1 ||
        bus.alu_input_two_mux_sel !== x2 || bus.stall_id !== xs) begin
      n_fail++;
      $display("FAIL %s: got sel1=%0d sel2=%0d stall=%0b, want %0d %0d %0b",
               nm, bus.alu_input_one_mux_sel, bus.alu_input_two_mux_sel,
               bus.stall_id, x1, x2, xs);
    end
    @(posedge clk);
    m_clock(id, adv, fl, rst, m_stall(id, adv, fl));
    #1;
  endtask

  initial begin
    ins_t nop;
    ins_t a1;
    ins_t use2;
    nop  = '0;
    a1   = alu(3'd1, 3'd2, 1'b1, 3'd3, 1'b1);
    use2 = alu(3'd3, 3'd2, 1'b1, 3'd2, 1'b1);

    add(a1,                              1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(alu(3'd4, 3'd1, 1, 3'd1, 1),     1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd1, 2'd1, 1'b0);
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(a1,                              1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(alu(3'd5, 3'd1, 1, 3'd1, 0),     1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd2, 2'd0, 1'b0);
    add(a1,                              1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(a1,                              1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(alu(3'd6, 3'd1, 1, 3'd1, 1),     1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd1, 2'd1, 1'b0);
    add(ldr(3'd2, 3'd7),                 1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(use2,                            1, 0, 0, 2'd0, 2'd0, ST);
`ifdef FWD_MEM_LOAD_EN
    add(nop,                             1, 0, 0, 2'd3, 2'd3, 1'b0);
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);
`else
    add(use2,                            1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd2, 2'd2, 1'b0);
`endif
    add(ldr(3'd2, 3'd7),                 1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(use2,                            1, 1, 0, 2'd0, 2'd0, 1'b0);
    add(alu(3'd4, 3'd3, 1, 3'd3, 1),     1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(ldr(3'd2, 3'd4),                 1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(use2,                            0, 0, 0, 2'd2, 2'd0, ST);
    add(use2,                            0, 0, 0, 2'd2, 2'd0, ST);
    add(use2,                            0, 0, 0, 2'd2, 2'd0, ST);
    add(use2,                            1, 0, 0, 2'd2, 2'd0, ST);
`ifdef FWD_MEM_LOAD_EN
    add(nop,                             1, 0, 0, 2'd3, 2'd3, 1'b0);
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);
`else
    add(use2,                            1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(nop,                             1, 0, 0, 2'd2, 2'd2, 1'b0);
`endif
    add(ldr(3'd2, 3'd7),                 1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(use2,                            1, 0, 0, 2'd0, 2'd0, ST);
`ifdef FWD_MEM_LOAD_EN
    add(nop,                             1, 0, 1, 2'd3, 2'd3, 1'b0);
`else
    add(use2,                            1, 0, 1, 2'd0, 2'd0, 1'b0);
`endif
    add(ldr(3'd2, 3'd7),                 1, 0, 0, 2'd0, 2'd0, 1'b0);
    add(use2,                            1, 0, 0, 2'd0, 2'd0, ST);
`ifdef FWD_MEM_LOAD_EN
    add(nop,                             1, 0, 0, 2'd3, 2'd3, 1'b0);
`else
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);
`endif
    add(nop,                             1, 0, 0, 2'd0, 2'd0, 1'b0);

    drive(nop, 1'b1, 1'b0, 1'b1);
    repeat (2) begin
      @(posedge clk);
      m_clock(nop, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    #1;

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].id, tbl[i].adv, tbl[i].fl,
           tbl[i].rst, 1'b0, tbl[i].e1, tbl[i].e2, tbl[i].es);

    for (int i = 0; i < 3000; i++) begin
      ins_t r;
      bit   adv;
      bit   fl;
      bit   rst;
      r.v  = ($urandom_range(0, 9) != 0);
      r.d  = 3'($urandom_range(0, 3));
      r.rw = ($urandom_range(0, 5) != 0);
      r.ld = ($urandom_range(0, 2) == 0);
      r.s1 = 3'($urandom_range(0, 3));
      r.u1 = ($urandom_range(0, 4) != 0);
      r.s2 = 3'($urandom_range(0, 3));
      r.u2 = ($urandom_range(0, 2) != 0);
      adv  = ($urandom_range(0, 4) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 99) < 2);
      step($sformatf("rand%0d", i), r, adv, fl, rst, 1'b1,
           2'd0, 2'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Forwarding and load-use hazard controller for the EX stage of the pipelined LC-3b core. It keeps its own shadow of the destination register, write-enable and load flag for each instruction in EX, MEM and WB, advancing in lockstep with the pipeline registers. It drives the two 2-bit operand-forwarding selects consumed by `ex_datapath`, and it inserts a one-cycle bubble for load-use hazards when MEM-stage load forwarding is compiled out.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `id_valid`  in  1  the ID stage holds a real instruction
- `id_src1`, `id_src2`  in  3 each  source register numbers of the ID instruction
- `id_src1_used`, `id_src2_used`  in  1 each  the ALU operand actually reads that register (0 for immediate, PC-relative or branch-address operands)
- `id_dest`  in  3  destination register of the ID instruction
- `id_regwrite`  in  1  the ID instruction writes the register file
- `id_is_load`  in  1  the ID instruction is LDB, LDR or LDI
- `advance`  in  1  pipeline registers load this cycle; low during memory stalls
- `flush`  in  1  squash the ID instruction on taken branch/jump
- `alu_input_one_mux_sel`  out  2  forwarding select for operand 1: 0 none, 1 mem_input, 2 wb_input, 3 mem_load_input
- `alu_input_two_mux_sel`  out  2  forwarding select for operand 2, same encoding
- `stall_id`  out  1  hold PC and the IF/ID register, inject a bubble into EX

## Operation
- Shadow stages EX, MEM, WB each hold: `valid`, `dest[2:0]`, `regwrite`, `is_load`. EX additionally holds `src1`, `src2`, `src1_used`, `src2_used`.
- On a clock with `advance`=1:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes the ID fields, except that EX becomes a bubble (`valid`=0) when `flush`=1 or `stall_id`=1.
- On a clock with `advance`=0, all shadows hold, the FSM holds, and `flush` is ignored.
- A stage "writes rN" when `valid & regwrite & dest==N`. R0 is an ordinary register.
- Select for operand k (k=1,2), evaluated only when EX `valid & srck_used`; otherwise 0:
  - MEM writes `srck`: 3 if MEM `is_load`, else 1.
  - else WB writes `srck`: 2.
  - else: 0.
  - MEM has priority over WB when both match.
- Load-use hazard: EX `valid & is_load & regwrite`, and ID `id_valid` with (`id_src1_used & id_src1==EX.dest`) or (`id_src2_used & id_src2==EX.dest`).
- FSM, present only without the macro:
  - States IDLE and LU_STALL.
  - IDLE → LU_STALL when a hazard is present and `advance`=1.
  - LU_STALL → IDLE on the next `advance`=1.
  - In LU_STALL, `stall_id`=0, because the bubble has already separated the load from the user.
  - A `flush` with `advance`=1 forces IDLE.

## Timing
- Reset values: all shadow `valid`=0, FSM=IDLE, both selects = 0, `stall_id`=0.
- Selects are combinational from registered EX/MEM/WB shadows and are stable for the whole cycle; there is no additional latency.
- `stall_id` is combinational from the ID inputs and the EX shadow, and is asserted in the same cycle as the hazard.
- Back-to-back loads to the same register need one stall per dependent consumer, never two.
- `flush` and hazard in the same cycle: flush wins, `stall_id`=0, EX gets a bubble.
- `reset` asserted mid-stall returns to IDLE at the next edge and clears all shadows.
- `advance`=0 during LU_STALL extends the stall state without re-asserting `stall_id`.

## Configuration
- `FWD_MEM_LOAD_EN` defined:
  - A MEM-stage load producer forwards via select 3 (mem_load_input).
  - Load-use detection, the FSM and `stall_id` are compiled out, and `stall_id` is tied to 0.
- Undefined:
  - Load-use hazards stall one cycle, and the dependent instruction then forwards from WB (select 2).
  - Select 3 is never produced.

## Test plan
- ADD R1←R2,R3 followed immediately by ADD R4←R1,R1, with `advance` held 1 → in the second instruction's EX cycle, both selects = 1.
- ADD R1, then NOP, then AND R5←R1,#3 → operand1 select = 2, operand2 select = 0 (immediate, `src2_used`=0).
- ADD R1 in WB and ADD R1 in MEM, with the EX instruction reading R1 → select = 1 (MEM priority).
- LDR R2, then ADD R3←R2,R2, without macro → `stall_id`=1 for exactly one advancing cycle, EX bubble, then selects = 2. With macro → `stall_id`=0 and selects = 3.
- Load-use hazard with `flush`=1 in the same cycle → `stall_id`=0 and EX `valid`=0 next cycle. Load-use hazard with `advance`=0 for 3 cycles → shadows and selects unchanged throughout.
- `reset` pulsed while in LU_STALL → next cycle: selects 0, `stall_id` 0, FSM IDLE.
